// File: rtl/cordic_engine.sv
// One rotation-mode CORDIC micro-rotation stage: rotates (x,y) by +/-atan(2^-i)
// toward a zero residual angle, with quadrant tag and valid carried alongside.
module cordic_engine #(
  parameter  int DATA_WIDTH = 18,
  parameter  int N_PE       = 15,
  localparam int CNT_W      = $clog2(N_PE + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic signed [DATA_WIDTH-1:0] in_x,
  input  logic signed [DATA_WIDTH-1:0] in_y,
  input  logic signed [DATA_WIDTH-1:0] in_alpha,
  input  logic signed [DATA_WIDTH-1:0] in_atan,
  input  logic        [CNT_W-1:0]      i_count,
  input  logic        [1:0]            i_quadrant,
  input  logic                         valid_in,
  output logic signed [DATA_WIDTH-1:0] out_x,
  output logic signed [DATA_WIDTH-1:0] out_y,
  output logic signed [DATA_WIDTH-1:0] out_alpha,
  output logic        [1:0]            out_quadrant,
  output logic                         valid_out
);

  logic signed [DATA_WIDTH-1:0] w_xs;
  logic signed [DATA_WIDTH-1:0] w_ys;
  logic                         w_dir_pos;
  logic signed [DATA_WIDTH-1:0] w_x_next;
  logic signed [DATA_WIDTH-1:0] w_y_next;
  logic signed [DATA_WIDTH-1:0] w_a_next;

  logic signed [DATA_WIDTH-1:0] r_x;
  logic signed [DATA_WIDTH-1:0] r_y;
  logic signed [DATA_WIDTH-1:0] r_alpha;
  logic        [1:0]            r_quadrant;
  logic                         r_valid;

  // Arithmetic shift on signed operands sign-fills, even for shifts >= DATA_WIDTH.
  assign w_xs      = in_x >>> i_count;
  assign w_ys      = in_y >>> i_count;
  assign w_dir_pos = ~in_alpha[DATA_WIDTH-1];

  always_comb begin
    w_x_next = '0;
    w_y_next = '0;
    w_a_next = '0;
    if (w_dir_pos) begin
      w_x_next = in_x - w_ys;
      w_y_next = in_y + w_xs;
      w_a_next = in_alpha - in_atan;
    end else begin
      w_x_next = in_x + w_ys;
      w_y_next = in_y - w_xs;
      w_a_next = in_alpha + in_atan;
    end
  end

  // Data and quadrant only load on valid samples; otherwise they hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_alpha    <= '0;
      r_quadrant <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_x        <= w_x_next;
        r_y        <= w_y_next;
        r_alpha    <= w_a_next;
        r_quadrant <= i_quadrant;
      end
    end
  end

  assign out_x        = r_x;
  assign out_y        = r_y;
  assign out_alpha    = r_alpha;
  assign out_quadrant = r_quadrant;
  assign valid_out    = r_valid;

endmodule

// File: tb/tb_cordic_engine.sv
// Directed self-checking bench for cordic_engine: single-stage vectors, pass-through,
// async reset behaviour and a 15-stage chain computing cos/sin of pi/6.
module tb_cordic_engine;

  localparam int DW = 18;
  localparam int NP = 15;
  localparam int CW = $clog2(NP + 1);

  logic                 i_clk;
  logic                 i_rst_n;
  logic signed [DW-1:0] in_x, in_y, in_alpha, in_atan;
  logic        [CW-1:0] i_count;
  logic        [1:0]    i_quadrant;
  logic                 valid_in;
  logic signed [DW-1:0] out_x, out_y, out_alpha;
  logic        [1:0]    out_quadrant;
  logic                 valid_out;

  int nCompared;
  int nMismatched;

  cordic_engine #(.DATA_WIDTH(DW), .N_PE(NP)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .in_x(in_x), .in_y(in_y), .in_alpha(in_alpha), .in_atan(in_atan),
    .i_count(i_count), .i_quadrant(i_quadrant), .valid_in(valid_in),
    .out_x(out_x), .out_y(out_y), .out_alpha(out_alpha),
    .out_quadrant(out_quadrant), .valid_out(valid_out)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // 15-stage chain for the cos/sin accuracy check
  logic signed [DW-1:0] chX [0:NP];
  logic signed [DW-1:0] chY [0:NP];
  logic signed [DW-1:0] chA [0:NP];
  logic        [1:0]    chQ [0:NP];
  logic                 chV [0:NP];

  function automatic logic signed [DW-1:0] atanQ14(input int k);
    case (k)
      0: return 18'sd12868;  1: return 18'sd7596;  2: return 18'sd4014;
      3: return 18'sd2037;   4: return 18'sd1023;  5: return 18'sd512;
      6: return 18'sd256;    7: return 18'sd128;   8: return 18'sd64;
      9: return 18'sd32;    10: return 18'sd16;   11: return 18'sd8;
      12: return 18'sd4;    13: return 18'sd2;    default: return 18'sd1;
    endcase
  endfunction

  for (genvar k = 0; k < NP; k++) begin : gChain
    cordic_engine #(.DATA_WIDTH(DW), .N_PE(NP)) stage (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .in_x(chX[k]), .in_y(chY[k]), .in_alpha(chA[k]), .in_atan(atanQ14(k)),
      .i_count(CW'(k)), .i_quadrant(chQ[k]), .valid_in(chV[k]),
      .out_x(chX[k+1]), .out_y(chY[k+1]), .out_alpha(chA[k+1]),
      .out_quadrant(chQ[k+1]), .valid_out(chV[k+1])
    );
  end

  typedef struct {
    logic [CW-1:0]        cnt;
    logic signed [DW-1:0] x, y, a, t;
    logic [1:0]           q;
    logic signed [DW-1:0] ex, ey, ea;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int target, input int tol);
    nCompared++;
    if (actual < target - tol || actual > target + tol) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d +/- %0d", name, actual, target, tol);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input logic vin);
    @(negedge i_clk);
    i_count    = v.cnt;
    in_x       = v.x;
    in_y       = v.y;
    in_alpha   = v.a;
    in_atan    = v.t;
    i_quadrant = v.q;
    valid_in   = vin;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    i_rst_n = 1'b0;
    in_x = '0; in_y = '0; in_alpha = '0; in_atan = '0;
    i_count = '0; i_quadrant = '0; valid_in = 1'b0;
    chX[0] = '0; chY[0] = '0; chA[0] = '0; chQ[0] = '0; chV[0] = 1'b0;

    //            cnt  x        y        alpha    atan    q   ex       ey       ea
    vecs[0] = '{4'd0,  18'sd9949, 18'sd0,   18'sd12868, 18'sd12868, 2'd0, 18'sd9949,  18'sd9949, 18'sd0};
    vecs[1] = '{4'd1,  18'sd16384, 18'sd0,  -18'sd100,  18'sd7596,  2'd1, 18'sd16384, -18'sd8192, 18'sd7496};
    vecs[2] = '{4'd2,  18'sd0,    18'sd4096, 18'sd0,    18'sd4014,  2'd2, -18'sd1024, 18'sd4096, -18'sd4014};
    // wrap: y' = 131071 + 131071 overflows to -2
    vecs[3] = '{4'd0,  18'sd131071, 18'sd131071, 18'sd0, 18'sd1,    2'd3, 18'sd0,     -18'sd2,   -18'sd1};
    // large shift on negatives leaves only sign bits (-1)
    vecs[4] = '{4'd15, -18'sd5,   -18'sd3,  18'sd10,   18'sd1,     2'd0, -18'sd4,    -18'sd4,   18'sd9};
    vecs[5] = '{4'd3,  18'sd800,  18'sd1600, -18'sd50, 18'sd2037,   2'd1, 18'sd1000,  18'sd1500, 18'sd1987};

    #12;
    checkOutput("reset_x", out_x, 0);
    checkOutput("reset_y", out_y, 0);
    checkOutput("reset_alpha", out_alpha, 0);
    checkOutput("reset_valid", valid_out, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], 1'b1);
      checkOutput($sformatf("v%0d_x", i), out_x, vecs[i].ex);
      checkOutput($sformatf("v%0d_y", i), out_y, vecs[i].ey);
      checkOutput($sformatf("v%0d_alpha", i), out_alpha, vecs[i].ea);
      checkOutput($sformatf("v%0d_quad", i), out_quadrant, vecs[i].q);
      checkOutput($sformatf("v%0d_valid", i), valid_out, 1);
    end

    // pass-through with quadrant 3, then an invalid sample must not disturb data
    applyStimulus('{4'd0, 18'sd100, 18'sd0, 18'sd5, 18'sd5, 2'd3, 18'sd0, 18'sd0, 18'sd0}, 1'b1);
    checkOutput("pt_quad", out_quadrant, 3);
    checkOutput("pt_valid", valid_out, 1);
    checkOutput("pt_x", out_x, 100);
    checkOutput("pt_y", out_y, 100);
    applyStimulus('{4'd1, 18'sd777, 18'sd333, -18'sd9, 18'sd7, 2'd1, 18'sd0, 18'sd0, 18'sd0}, 1'b0);
    checkOutput("hold_valid", valid_out, 0);
    checkOutput("hold_x", out_x, 100);
    checkOutput("hold_y", out_y, 100);
    checkOutput("hold_alpha", out_alpha, 0);
    checkOutput("hold_quad", out_quadrant, 3);

    // async reset mid-stream, between edges
    applyStimulus(vecs[0], 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("arst_x", out_x, 0);
    checkOutput("arst_y", out_y, 0);
    checkOutput("arst_quad", out_quadrant, 0);
    checkOutput("arst_valid", valid_out, 0);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    #1;
    checkOutput("arst_release_valid", valid_out, 0);
    applyStimulus(vecs[1], 1'b1);
    checkOutput("recover_y", out_y, -8192);
    checkOutput("recover_valid", valid_out, 1);

    // chain: cos/sin(pi/6)
    valid_in = 1'b0;
    @(negedge i_clk);
    chX[0] = 18'sd9949; chY[0] = 18'sd0; chA[0] = 18'sd8579; chQ[0] = 2'd0; chV[0] = 1'b1;
    @(negedge i_clk);
    chV[0] = 1'b0;
    begin
      int lat;
      bit seen;
      lat  = 1;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        if (chV[NP]) seen = 1'b1;
        else begin
          @(negedge i_clk);
          lat++;
        end
      end
      nCompared++;
      if (!seen) begin
        nMismatched++;
        $display("[TB] FAIL chain_timeout: got no valid, expected valid within 40 cycles");
      end else begin
        checkOutput("chain_latency", lat, NP);
        checkRange("chain_cos", chX[NP], 14189, 16);
        checkRange("chain_sin", chY[NP], 8192, 16);
        checkOutput("chain_quad", chQ[NP], 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
